mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised memory-access pipeline stage that sits between EXE and WB, replacing the fixed single-cycle MEM stage. It issues a request/acknowledge transaction to the data memory with arbitrary wait states. It aligns and sign/zero-extends load data and generates store byte strobes for DATA_W of 32 or 64. It also drives a bypass port that tells the hazard unit whether its result can be forwarded yet.

## Interface
- DATA_W, 32, data/address width; 32 or 64 only
- SB_W, 48, width of opaque sideband carried EXE→WB unchanged (PC, control bits)
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- in_valid / in_ready  in/out  1  EXE→MEM handshake; in_ready is MEM_allow_in
- in_is_load, in_is_store  in  1  memory op flags; both 0 means pass-through
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only if DATA_W=64)
- in_signed  in  1  sign-extend load
- in_addr  in  DATA_W  ALU result / effective address
- in_wdata  in  DATA_W  store data, right-justified
- in_rf_we, in_rf_waddr  in  1/5  register write control
- in_sb  in  SB_W  sideband
- out_valid / out_ready  out/in  1  MEM→WB handshake
- out_rf_we, out_rf_waddr, out_rf_wdata  out  1/5/DATA_W  writeback
- out_sb  out  SB_W  sideband
- out_excp  out  1  misaligned-access flag
- mem_req, mem_wr  out  1  request valid, write
- mem_size  out  2  access size
- mem_addr, mem_wdata  out  DATA_W  address, lane-replicated data
- mem_wstrb  out  DATA_W/8  byte strobes
- mem_addr_ok, mem_data_ok  in  1  request accepted, response/read data valid
- mem_rdata  in  DATA_W  read data
- by_valid, by_data_ok  out  1  stage holds a reg-writing instr / its value is final
- by_waddr, by_wdata  out  5/DATA_W  forwarding destination and value

## Operation
- FSM states: EMPTY, REQ, RESP, DONE. Reset → EMPTY. Reset values: all outputs 0, including mem_req, out_valid, by_valid.
- in_ready = EMPTY | (DONE & out_ready). On accept, latch all inputs. Memory op → REQ. Pass-through → DONE with out_rf_wdata = in_addr.
- REQ: mem_req=1. mem_addr, mem_wdata, mem_wstrb, mem_size, and mem_wr are held stable until mem_addr_ok. On mem_addr_ok → RESP.
- RESP: wait for mem_data_ok; loads and stores both wait. On mem_data_ok, latch the extended load result and go to DONE.
- DONE: out_valid=1. On out_ready with no new accept → EMPTY.
- mem_data_ok or mem_addr_ok seen outside RESP/REQ respectively is ignored.
- Load: shift mem_rdata right by 8·addr[OFF-1:0], where OFF=log2(DATA_W/8). Then extend per in_size/in_signed.
- Store: mem_wdata replicates the low 2^size bytes across all lanes. mem_wstrb = ((1<<2^size)-1) << offset.
- out_rf_we = latched rf_we & ~out_excp.
- Bypass: by_valid = (state≠EMPTY) & rf_we. by_data_ok = DONE. by_wdata = result register.

## Timing
- Pass-through: accept at T, out_valid at T+1. Back-to-back accepts sustain 1 instr/cycle while out_ready=1.
- Memory op with zero-wait memory: accept T, mem_req T+1 (addr_ok T+1), data_ok T+2, out_valid T+3.
- Each wait cycle on addr_ok or data_ok adds one cycle. There is no timeout.
- Reset mid-transaction drops mem_req in the next cycle. Late responses are ignored per the rule above.
- in_ready never depends combinationally on mem_* inputs.

## Configuration
- MEM_STAGE_MISALIGN_CHECK_EN defined: an access whose offset is not a multiple of 2^size issues no mem_req. It goes accept → DONE with out_excp=1 and out_rf_we=0.
- Undefined: offset low bits below the size are cleared (aligned down), the access proceeds normally, and out_excp is tied 0.

## Structure
- mem_stage_pkg: FSM state enum, size codes (SZ_B/H/W/D), OFF width function.
- One combinational sub-module, mem_align: load extract/extend and store replicate/strobe generation, parametrised by DATA_W.

## Test plan
- DATA_W=32, pass-through stream of 4 instrs, out_ready=1 → outputs on 4 consecutive cycles, wdata = addr values, no mem_req.
- lb signed, addr 0x1003, mem_rdata 0x80FFFFFF, zero wait → out_rf_wdata 0xFFFFFF80 at T+3.
- sh 0x1234 at addr 0x2002, addr_ok delayed 3 cycles → mem_wstrb 4'b1100, mem_wdata 0x12341234 stable throughout REQ, out_rf_we=0.
- DATA_W=64, ld dword unsigned at 0x8, data_ok delayed 2 → out_valid at T+5, by_data_ok only in DONE.
- lw at 0x1002 → with macro: out_excp=1, no mem_req, out_valid at T+1; without: mem_addr 0x1000.
- Reset asserted in RESP, then data_ok → state EMPTY, no out_valid, mem_req=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM state enum, access-size codes and byte-offset width helper for mem_access_stage
package mem_stage_pkg;
  typedef enum logic [1:0] {EMPTY, REQ, RESP, DONE} state_t;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: combinational load shift/extend and store lane replication/strobes; in size, sgn, off, rdata, wdata; out ldata, sdata, strb
module mem_align import mem_stage_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                size,
  input  logic                      sgn,
  input  logic [off_w(DATA_W)-1:0]  off,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         ldata,
  output logic [DATA_W-1:0]         sdata,
  output logic [DATA_W/8-1:0]       strb
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] sh;
  logic [NB-1:0] m;
  assign sh = rdata >> {off, 3'b000};
  always_comb begin
    ldata = size == SZ_B ? (sgn ? DATA_W'($signed(sh[7:0])) : DATA_W'(sh[7:0]))
          : size == SZ_H ? (sgn ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0]))
          : size == SZ_W ? (sgn ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0])) : sh;
    sdata = size == SZ_B ? {NB{wdata[7:0]}} : size == SZ_H ? {(NB/2){wdata[15:0]}}
          : size == SZ_W ? {(NB/4){wdata[31:0]}} : wdata;
    m = size == SZ_B ? NB'(1) : size == SZ_H ? NB'(3) : size == SZ_W ? NB'(15) : '1;
    strb = m << off;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: EXE->WB memory stage (in_* handshake, mem_* req/ack port, out_* writeback, by_* bypass); define MEM_STAGE_MISALIGN_CHECK_EN to trap misaligned accesses instead of aligning down
module mem_access_stage import mem_stage_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SB_W   = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [DATA_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_rf_we,
  input  logic [4:0]          in_rf_waddr,
  input  logic [SB_W-1:0]     in_sb,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_rf_we,
  output logic [4:0]          out_rf_waddr,
  output logic [DATA_W-1:0]   out_rf_wdata,
  output logic [SB_W-1:0]     out_sb,
  output logic                out_excp,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                by_valid,
  output logic                by_data_ok,
  output logic [4:0]          by_waddr,
  output logic [DATA_W-1:0]   by_wdata
);
  localparam int OFF = off_w(DATA_W);
  state_t state, state_nx;
  logic ld_q, st_q, sgn_q, we_q, excp_q, mem_op, mis, accept, req;
  logic [1:0] size_q;
  logic [4:0] waddr_q;
  logic [DATA_W-1:0] addr_q, wdata_q, res_q, ldata, sdata;
  logic [SB_W-1:0] sb_q;
  logic [DATA_W/8-1:0] strb;
  logic [OFF-1:0] amask;
  assign mem_op = in_is_load | in_is_store;
  assign amask = OFF'((32'd1 << in_size) - 32'd1);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign mis = mem_op & |(in_addr[OFF-1:0] & amask);
`else
  assign mis = 1'b0;
`endif
  // in_ready is a pure function of state and out_ready, never of the memory port
  assign in_ready = state == EMPTY | (state == DONE & out_ready);
  assign accept = in_valid & in_ready;
  always_ff @(posedge clk) state <= reset ? EMPTY : state_nx;
  always_comb begin
    state_nx = accept ? (mem_op & ~mis ? REQ : DONE)
             : state == REQ ? (mem_addr_ok ? RESP : REQ)
             : state == RESP ? (mem_data_ok ? DONE : RESP)
             : state == DONE & out_ready ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {ld_q, st_q, sgn_q, we_q, excp_q, size_q, waddr_q, addr_q, wdata_q, res_q, sb_q} <= '0;
    end else if (accept) begin
      ld_q <= in_is_load;
      st_q <= in_is_store;
      sgn_q <= in_signed;
      we_q <= in_rf_we;
      excp_q <= mis;
      size_q <= in_size;
      waddr_q <= in_rf_waddr;
      addr_q <= {in_addr[DATA_W-1:OFF], in_addr[OFF-1:0] & ~amask};
      wdata_q <= in_wdata;
      res_q <= in_addr;
      sb_q <= in_sb;
    end else if (state == RESP & mem_data_ok & ld_q) begin
      res_q <= ldata;
    end
  end
  mem_align #(.DATA_W(DATA_W)) u_align (
    .size(size_q), .sgn(sgn_q), .off(addr_q[OFF-1:0]), .rdata(mem_rdata), .wdata(wdata_q),
    .ldata(ldata), .sdata(sdata), .strb(strb)
  );
  assign req = state == REQ;
  always_comb begin
    mem_req = req;
    mem_wr = req & st_q;
    mem_size = req ? size_q : 2'b0;
    mem_addr = req ? addr_q : '0;
    mem_wdata = req ? sdata : '0;
    mem_wstrb = req & st_q ? strb : '0;
    out_valid = state == DONE;
    out_rf_we = we_q & ~excp_q;
    out_rf_waddr = waddr_q;
    out_rf_wdata = res_q;
    out_sb = sb_q;
    out_excp = excp_q;
    by_valid = state != EMPTY & we_q;
    by_data_ok = state == DONE;
    by_waddr = waddr_q;
    by_wdata = res_q;
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table, directed and randomized checks of mem_access_stage against a byte-level reference model
module tb_mem_access_stage;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic in_valid, in_ready, in_is_load, in_is_store, in_signed, in_rf_we;
  logic [1:0] in_size, mem_size;
  logic [31:0] in_addr, in_wdata, out_rf_wdata, mem_addr, mem_wdata, mem_rdata, by_wdata;
  logic [4:0] in_rf_waddr, out_rf_waddr, by_waddr;
  logic [47:0] in_sb, out_sb;
  logic out_valid, out_ready, out_rf_we, out_excp, mem_req, mem_wr, mem_addr_ok, mem_data_ok, by_valid, by_data_ok;
  logic [3:0] mem_wstrb;
  logic d_in_valid, d_in_ready, d_in_is_load, d_in_is_store, d_in_signed, d_in_rf_we;
  logic [1:0] d_in_size, d_mem_size;
  logic [63:0] d_in_addr, d_in_wdata, d_out_rf_wdata, d_mem_addr, d_mem_wdata, d_mem_rdata, d_by_wdata;
  logic [4:0] d_in_rf_waddr, d_out_rf_waddr, d_by_waddr;
  logic [47:0] d_in_sb, d_out_sb;
  logic d_out_valid, d_out_ready, d_out_rf_we, d_out_excp, d_mem_req, d_mem_wr, d_mem_addr_ok, d_mem_data_ok, d_by_valid, d_by_data_ok;
  logic [7:0] d_mem_wstrb;

  mem_access_stage #(.DATA_W(32), .SB_W(48)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
    .out_rf_wdata(out_rf_wdata), .out_sb(out_sb), .out_excp(out_excp), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .by_valid(by_valid), .by_data_ok(by_data_ok), .by_waddr(by_waddr), .by_wdata(by_wdata)
  );
  mem_access_stage #(.DATA_W(64), .SB_W(48)) dut64 (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_is_load(d_in_is_load),
    .in_is_store(d_in_is_store), .in_size(d_in_size), .in_signed(d_in_signed), .in_addr(d_in_addr),
    .in_wdata(d_in_wdata), .in_rf_we(d_in_rf_we), .in_rf_waddr(d_in_rf_waddr), .in_sb(d_in_sb),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rf_we(d_out_rf_we), .out_rf_waddr(d_out_rf_waddr),
    .out_rf_wdata(d_out_rf_wdata), .out_sb(d_out_sb), .out_excp(d_out_excp), .mem_req(d_mem_req),
    .mem_wr(d_mem_wr), .mem_size(d_mem_size), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
    .mem_wstrb(d_mem_wstrb), .mem_addr_ok(d_mem_addr_ok), .mem_data_ok(d_mem_data_ok), .mem_rdata(d_mem_rdata),
    .by_valid(d_by_valid), .by_data_ok(d_by_data_ok), .by_waddr(d_by_waddr), .by_wdata(d_by_wdata)
  );

  typedef struct {
    logic ld, st;
    logic [1:0] sz;
    logic sg;
    logic [31:0] addr, wdata, rdata;
    logic we;
    int aw, dw, e_lat;
    logic [31:0] e_res, e_maddr, e_mwdata;
    logic [3:0] e_strb;
    logic e_excp;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int sz, input bit sg);
    int n;
    logic [63:0] v, mask;
    n = 1 << sz;
    v = {32'd0, rd} >> (8 * off);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_repl(input logic [31:0] wd, input int sz);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % (1 << sz)) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] ref_strb(input int off, input int sz);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + (1 << sz));
    return s;
  endfunction

  function automatic vec_t mk_exp(input vec_t v);
    int n, o, ao;
    bit mem;
    n = 1 << v.sz;
    o = int'(v.addr[1:0]);
    ao = o - (o % n);
    mem = v.ld || v.st;
    v.e_excp = CHK_EN && mem && (o % n != 0);
    v.e_maddr = v.addr - 32'(o % n);
    v.e_lat = (!mem || v.e_excp) ? 1 : v.aw + v.dw + 3;
    v.e_res = v.ld ? ref_load(v.rdata, ao, v.sz, v.sg) : v.addr;
    v.e_mwdata = ref_repl(v.wdata, v.sz);
    v.e_strb = ref_strb(ao, v.sz);
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string nm);
    logic [4:0] wa;
    logic [47:0] sb;
    logic [31:0] qa, qd;
    logic [3:0] qs;
    logic qw;
    logic [1:0] qz;
    int nreq, rc, lat;
    bit rnext, inresp, stable, byok_bad, byv_bad, mem;
    wa = 5'($urandom);
    sb = {16'($urandom), 32'($urandom)};
    nreq = 0; rc = 0; lat = 0; rnext = 0; inresp = 0; stable = 1; byok_bad = 0; byv_bad = 0;
    qa = '0; qd = '0; qs = '0; qw = 0; qz = '0;
    mem = (v.ld || v.st) && !v.e_excp;
    in_valid = 1; in_is_load = v.ld; in_is_store = v.st; in_size = v.sz; in_signed = v.sg;
    in_addr = v.addr; in_wdata = v.wdata; in_rf_we = v.we; in_rf_waddr = wa; in_sb = sb;
    @(posedge clk);
    #1;
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_addr = $urandom; in_wdata = $urandom;
    in_sb = '0; in_rf_waddr = '0; mem_rdata = v.rdata;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (by_data_ok !== out_valid) byok_bad = 1;
      if (by_valid !== v.we) byv_bad = 1;
      if (out_valid) begin
        lat = c;
        if (!v.st && !v.e_excp) chk({nm, ".res"}, out_rf_wdata, v.e_res);
        if (!v.st && !v.e_excp) chk({nm, ".by_wdata"}, by_wdata, v.e_res);
        chk({nm, ".rf_we"}, out_rf_we, v.we & ~v.e_excp);
        chk({nm, ".excp"}, out_excp, v.e_excp);
        chk({nm, ".waddr"}, {by_waddr, out_rf_waddr}, {wa, wa});
        chk({nm, ".sb"}, out_sb, sb);
      end
      if (rnext) begin
        inresp = 1;
        rnext = 0;
      end
      if (inresp) begin
        mem_data_ok = (rc == v.dw);
        if (mem_data_ok) inresp = 0;
        rc++;
      end else mem_data_ok = 0;
      if (mem_req) begin
        if (nreq == 0) begin
          qa = mem_addr; qd = mem_wdata; qs = mem_wstrb; qw = mem_wr; qz = mem_size;
        end else if ({qa, qd, qs, qw, qz} !== {mem_addr, mem_wdata, mem_wstrb, mem_wr, mem_size}) stable = 0;
        mem_addr_ok = (nreq == v.aw);
        rnext = mem_addr_ok;
        nreq++;
      end else mem_addr_ok = 0;
    end
    mem_addr_ok = 0;
    mem_data_ok = 0;
    chk({nm, ".lat"}, lat, v.e_lat);
    chk({nm, ".nreq"}, nreq, mem ? v.aw + 1 : 0);
    chk({nm, ".by_data_ok"}, byok_bad, 0);
    chk({nm, ".by_valid"}, byv_bad, 0);
    if (mem) begin
      chk({nm, ".maddr"}, qa, v.e_maddr);
      chk({nm, ".mwr"}, qw, v.st);
      chk({nm, ".msize"}, qz, v.sz);
      chk({nm, ".stable"}, stable, 1);
      if (v.st) chk({nm, ".mwdata"}, qd, v.e_mwdata);
      if (v.st) chk({nm, ".wstrb"}, qs, v.e_strb);
    end
  endtask

  task automatic do64(input string nm, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                      input logic [63:0] rd, input int dw, input logic [63:0] eres, input int elat);
    int lat;
    bit bad;
    lat = 0; bad = 0;
    d_in_valid = 1; d_in_is_load = 1; d_in_size = sz; d_in_signed = sg; d_in_addr = a; d_in_rf_we = 1;
    @(posedge clk);
    #1;
    d_in_valid = 0; d_in_addr = '1; d_mem_rdata = rd;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (d_by_data_ok !== d_out_valid) bad = 1;
      if (d_out_valid) begin
        lat = c;
        chk({nm, ".res"}, d_out_rf_wdata, eres);
      end
      if (c == 1) begin
        chk({nm, ".req"}, d_mem_req, 1);
        chk({nm, ".maddr"}, d_mem_addr, a);
        chk({nm, ".msize"}, d_mem_size, sz);
      end
      d_mem_addr_ok = (c == 1) && d_mem_req;
      d_mem_data_ok = (c == 2 + dw);
    end
    d_mem_addr_ok = 0;
    d_mem_data_ok = 0;
    chk({nm, ".lat"}, lat, elat);
    chk({nm, ".by_data_ok"}, bad, 0);
  endtask

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t v;
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_size = 0; in_signed = 0; in_addr = 0; in_wdata = 0;
    in_rf_we = 0; in_rf_waddr = 0; in_sb = 0; out_ready = 1; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    d_in_valid = 0; d_in_is_load = 0; d_in_is_store = 0; d_in_size = 0; d_in_signed = 0; d_in_addr = 0;
    d_in_wdata = 0; d_in_rf_we = 0; d_in_rf_waddr = 0; d_in_sb = 0; d_out_ready = 1;
    d_mem_addr_ok = 0; d_mem_data_ok = 0; d_mem_rdata = 0;
    //            ld st sz sg addr          wdata         rdata         we aw dw lat res           maddr         mwdata        strb  ex
    tbl[0] = '{1, 0, 0, 1, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 1, 0, 0, 3, 32'hFFFF_FF80, 32'h0000_1003, 32'h0,        4'h0, 0};
    tbl[1] = '{0, 1, 1, 0, 32'h0000_2002, 32'h0000_1234, 32'h0,        0, 3, 0, 6, 32'h0,        32'h0000_2002, 32'h1234_1234, 4'hC, 0};
    tbl[2] = '{1, 0, 1, 0, 32'h0000_0002, 32'h0,        32'hABCD_1234, 1, 0, 0, 3, 32'h0000_ABCD, 32'h0000_0002, 32'h0,        4'h0, 0};
    tbl[3] = '{1, 0, 1, 1, 32'h0000_0002, 32'h0,        32'hABCD_1234, 1, 1, 1, 5, 32'hFFFF_ABCD, 32'h0000_0002, 32'h0,        4'h0, 0};
    tbl[4] = '{1, 0, 0, 0, 32'h0000_0001, 32'h0,        32'h1234_8056, 1, 0, 2, 5, 32'h0000_0080, 32'h0000_0001, 32'h0,        4'h0, 0};
    tbl[5] = '{0, 1, 0, 0, 32'h0000_0003, 32'h0000_00A5, 32'h0,        0, 0, 0, 3, 32'h0,        32'h0000_0003, 32'hA5A5_A5A5, 4'h8, 0};
    tbl[6] = '{0, 1, 2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 1, 2, 6, 32'h0,        32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0};
    tbl[7] = '{0, 0, 2, 0, 32'h1234_5678, 32'h0,        32'h0,        1, 0, 0, 1, 32'h1234_5678, 32'h0,        32'h0,        4'h0, 0};
    tbl[8] = '{1, 0, 2, 0, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 1, 2, 0, 5, 32'hCAFE_F00D, 32'h0000_0008, 32'h0,        4'h0, 0};
    repeat (3) @(negedge clk);
    chk("rst.out_valid", {out_valid, d_out_valid}, 2'b00);
    chk("rst.mem_req", {mem_req, d_mem_req}, 2'b00);
    chk("rst.by_valid", {by_valid, d_by_valid}, 2'b00);
    chk("rst.wdata", {out_rf_wdata, by_wdata}, 64'h0);
    chk("rst.sb_excp", {out_sb, out_excp, out_rf_we, by_data_ok}, 0);
    chk("rst.mem_out", {mem_addr, mem_wdata, mem_wstrb, mem_wr, mem_size}, 0);
    reset = 0;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    in_is_load = 0; in_is_store = 0; in_rf_we = 1; in_valid = 1; in_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pt.valid", out_valid, 1);
      chk("pt.wdata", out_rf_wdata, 32'h100 + i);
      chk("pt.req", mem_req, 0);
      in_addr = 32'h101 + i;
      in_valid = i < 3;
    end
    @(negedge clk);
    chk("pt.drain", out_valid, 0);
    for (int i = 0; i < 9; i++) do_op(tbl[i], $sformatf("tbl%0d", i));
    v = tbl[8];
    v.addr = 32'h0000_1002; v.aw = 0; v.dw = 0;
    v = mk_exp(v);
    do_op(v, "lw_mis");
    chk("lw_mis.model", {v.e_excp, v.e_maddr}, CHK_EN ? {1'b1, 32'h1000} : {1'b0, 32'h1000});
    for (int i = 0; i < 150; i++) begin
      int k;
      v = tbl[7];
      k = $urandom_range(0, 2);
      v.ld = k == 1; v.st = k == 2; v.sz = 2'($urandom_range(0, 2)); v.sg = 1'($urandom);
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom; v.we = v.st ? 1'b0 : 1'($urandom);
      v.aw = $urandom_range(0, 3); v.dw = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.sz) - 32'd1);
      do_op(mk_exp(v), "rnd");
    end
    in_valid = 1; in_is_load = 1; in_size = 2; in_addr = 32'h40; in_rf_we = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("rresp.req", mem_req, 1);
    mem_addr_ok = 1;
    @(negedge clk);
    mem_addr_ok = 0;
    chk("rresp.resp_noreq", mem_req, 0);
    chk("rresp.by_valid", by_valid, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rresp.after_rst", {mem_req, by_valid, out_valid, in_ready}, 4'b0001);
    mem_data_ok = 1;
    @(negedge clk);
    mem_data_ok = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rresp.late", {out_valid, mem_req, by_data_ok}, 3'b000);
    end
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("rreq.req", mem_req, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rreq.dropped", mem_req, 0);
    mem_addr_ok = 1;
    mem_data_ok = 1;
    @(negedge clk);
    mem_addr_ok = 0;
    mem_data_ok = 0;
    @(negedge clk);
    chk("rreq.late", {out_valid, mem_req}, 2'b00);
    do64("ld64", 2'd3, 1'b0, 64'h8, 64'h8123_4567_89AB_CDEF, 2, 64'h8123_4567_89AB_CDEF, 5);
    do64("lb64", 2'd0, 1'b1, 64'hF, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 3);
    do64("lw64", 2'd2, 1'b1, 64'h4, 64'h8000_0001_0000_0000, 1, 64'hFFFF_FFFF_8000_0001, 4);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
